// File: rtl/memory_stage_pkg.sv
// Shared widths, RAM geometry and memory-mapped IO addresses for the memory stage.
package memory_stage_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned RAM_IDX_W = 10;

    localparam logic [DATA_W-1:0] IO_IN_ADDR  = 16'hFFFE;
    localparam logic [DATA_W-1:0] IO_OUT_ADDR = 16'hFFFF;

    // Where the registered load value comes from in the writeback cycle.
    typedef enum logic [1:0] {
        LOAD_ZERO = 2'd0,
        LOAD_RAM  = 2'd1,
        LOAD_IO   = 2'd2
    } loadSrc_t;

    // True when the full 16-bit address falls inside the RAM window.
    function automatic logic isRamAddr(input logic [DATA_W-1:0] addr);
        return addr[DATA_W-1:RAM_IDX_W] == '0;
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// 1024x16 word RAM: synchronous write, synchronous read, no reset.
module data_memory
    import memory_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 writeEnable,
    input  logic                 readEnable,
    input  logic [RAM_IDX_W-1:0] address,
    input  logic [DATA_W-1:0]    writeData,
    output logic [DATA_W-1:0]    readData
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // Write and read on the same edge; a held read port keeps its last word.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[address] <= writeData;
        end
        if (readEnable) begin
            readData <= mem[address];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: address decode, data RAM, IO port register, MEM/WB register and forwarding taps.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              IRegWrite,
    input  logic              IMemWrite,
    input  logic              IMemRead,
    input  logic              IRegStore,
    input  logic [DATA_W-1:0] IOPCP2,
    input  logic [DATA_W-1:0] IALUResult,
    input  logic [DATA_W-1:0] I3rdArg,
    input  logic [DATA_W-1:0] IRd,
    input  logic              IStall,
    input  logic [DATA_W-1:0] IIOIn,
    output logic              ORegWrite,
    output logic              ORegStore,
    output logic [DATA_W-1:0] OPCP2,
    output logic [DATA_W-1:0] OALUResult,
    output logic [DATA_W-1:0] OLoadData,
    output logic [DATA_W-1:0] ORd,
    output logic [DATA_W-1:0] ALUResultMEM,
    output logic [DATA_W-1:0] rdMEM,
    output logic [DATA_W-1:0] loadDataWB,
    output logic [DATA_W-1:0] rdWB,
    output logic [DATA_W-1:0] OIOOut
);

    logic              isRam;
    logic              isIoIn;
    logic              isIoOut;
    logic              storeEn;
    logic              ramWe;
    logic              ioWe;
    logic [DATA_W-1:0] ramReadData;
    loadSrc_t          loadSrc;
    loadSrc_t          nextLoadSrc;
    logic [DATA_W-1:0] loadIoData;
    logic [DATA_W-1:0] nextLoadIoData;

    // Full 16-bit decode so nothing above the RAM window aliases into it.
    assign isRam   = isRamAddr(IALUResult);
    assign isIoIn  = (IALUResult == IO_IN_ADDR);
    assign isIoOut = (IALUResult == IO_OUT_ADDR);

    // Stores are dropped while stalled or in reset; 0xFFFE and unmapped targets never match.
    assign storeEn = IMemWrite && !IStall && !reset;
    assign ramWe   = storeEn && isRam;
    assign ioWe    = storeEn && isIoOut;

    data_memory uRam (
        .clk         (clk),
        .writeEnable (ramWe),
        .readEnable  (!IStall),
        .address     (IALUResult[RAM_IDX_W-1:0]),
        .writeData   (I3rdArg),
        .readData    (ramReadData)
    );

    // Choose the load source; a combined read+write or a non-load yields zero.
    always_comb begin
        nextLoadSrc    = LOAD_ZERO;
        nextLoadIoData = '0;
        if (IMemRead && !IMemWrite) begin
            if (isRam) begin
                nextLoadSrc = LOAD_RAM;
            end else if (isIoIn) begin
                nextLoadSrc    = LOAD_IO;
                nextLoadIoData = IIOIn;
            end else if (isIoOut) begin
                nextLoadSrc    = LOAD_IO;
                nextLoadIoData = OIOOut;
            end
        end
    end

    // MEM/WB register and IO output port; reset wins over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ORegWrite  <= 1'b0;
            ORegStore  <= 1'b0;
            OPCP2      <= '0;
            OALUResult <= '0;
            ORd        <= '0;
            loadSrc    <= LOAD_ZERO;
            loadIoData <= '0;
            OIOOut     <= '0;
        end else begin
            if (ioWe) begin
                OIOOut <= I3rdArg;
            end
            if (!IStall) begin
                ORegWrite  <= IRegWrite;
                ORegStore  <= IRegStore;
                OPCP2      <= IOPCP2;
                OALUResult <= IALUResult;
                ORd        <= IRd;
                loadSrc    <= nextLoadSrc;
                loadIoData <= nextLoadIoData;
            end
        end
    end

    // Load data is a mux of registered sources, so it lines up with the rest of MEM/WB.
    always_comb begin
        OLoadData = '0;
        case (loadSrc)
            LOAD_RAM: OLoadData = ramReadData;
            LOAD_IO:  OLoadData = loadIoData;
            default:  OLoadData = '0;
        endcase
    end

    // Forwarding taps for the execute stage.
    assign ALUResultMEM = IALUResult;
    assign rdMEM        = IRd;
    assign loadDataWB   = ORegStore ? OLoadData : OALUResult;
    assign rdWB         = ORd;

endmodule
